// File: rtl/stg5wb_pkg.sv
// Shared definitions for the writeback stage: opcode values, opcode width and FSM states.
package stg5wb_pkg;

  localparam int unsigned OPC_W = 6;

  localparam logic [OPC_W-1:0] OpcNop  = 6'h00;
  localparam logic [OPC_W-1:0] OpcAdd  = 6'h01;
  localparam logic [OPC_W-1:0] OpcSt   = 6'h02;
  localparam logic [OPC_W-1:0] OpcHalt = 6'h3f;

  typedef enum logic {
    StRun    = 1'b0,
    StHalted = 1'b1
  } wb_state_e;

  // Bubbles, including the all-zero reset output of stg4mo, never retire.
  function automatic logic is_retire(wb_state_e st, logic [OPC_W-1:0] opc);
    return (st == StRun) && (opc != OpcNop);
  endfunction

endpackage

// File: rtl/stg5wb_wb_counter.sv
// Wrapping counter with enable and a sticky flag that sets when the count wraps to zero.
module stg5wb_wb_counter #(
  parameter int unsigned CntW = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  output logic [CntW-1:0] cnt_o,
  output logic            ovf_o
);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ovf_q, ovf_d;

  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (en_i) begin
      cnt_d = cnt_q + CntW'(1);
      if (&cnt_q) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/stg5wb.sv
// Writeback stage: register-file write ports, two-deep forwarding taps, retire/cycle counters
// and the halt/resume state machine that freezes architectural writes.
module stg5wb
  import stg5wb_pkg::*;
#(
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned ADDR_W   = 24,
  parameter int unsigned TGT_GP_W = 4,
  parameter int unsigned TGT_SR_W = 2,
  parameter int unsigned CNT_W    = 32
) (
  input  logic                iw_clk,
  input  logic                iw_rst_n,
  input  logic [ADDR_W-1:0]   iw_pc,
  input  logic [DATA_W-1:0]   iw_instr,
  input  logic [OPC_W-1:0]    iw_opc,
  input  logic [TGT_GP_W-1:0] iw_tgt_gp,
  input  logic                iw_tgt_gp_we,
  input  logic [TGT_SR_W-1:0] iw_tgt_sr,
  input  logic                iw_tgt_sr_we,
  input  logic [DATA_W-1:0]   iw_result,
  input  logic                iw_resume,
  output logic                ow_gp_we,
  output logic [TGT_GP_W-1:0] ow_gp_waddr,
  output logic [DATA_W-1:0]   ow_gp_wdata,
  output logic                ow_sr_we,
  output logic [TGT_SR_W-1:0] ow_sr_waddr,
  output logic [DATA_W-1:0]   ow_sr_wdata,
  output logic                ow_fwd0_we,
  output logic [TGT_GP_W-1:0] ow_fwd0_tgt,
  output logic [DATA_W-1:0]   ow_fwd0_data,
  output logic                ow_fwd1_we,
  output logic [TGT_GP_W-1:0] ow_fwd1_tgt,
  output logic [DATA_W-1:0]   ow_fwd1_data,
  output logic                ow_halted,
  output logic [ADDR_W-1:0]   ow_halt_pc,
  output logic [CNT_W-1:0]    ow_retired,
  output logic [CNT_W-1:0]    ow_cycles,
  output logic                ow_retired_ovf
);

  wb_state_e           state_q;
  logic [ADDR_W-1:0]   halt_pc_q;
  logic                fwd1_we_q, fwd1_we_d;
  logic [TGT_GP_W-1:0] fwd1_tgt_q, fwd1_tgt_d;
  logic [DATA_W-1:0]   fwd1_data_q, fwd1_data_d;
  logic                retire;
  logic                in_run;
  logic                cycles_ovf_unused;
  logic                instr_unused;

  // The instruction word is carried for debug visibility only.
  assign instr_unused = ^iw_instr;

  // Gating with the reset input keeps every write enable low while reset is held.
  assign in_run = (state_q == StRun);
  assign retire = iw_rst_n & is_retire(state_q, iw_opc);

  always_comb begin
    ow_gp_we    = retire & iw_tgt_gp_we;
    ow_gp_waddr = iw_tgt_gp;
    ow_gp_wdata = iw_result;
    ow_sr_we    = retire & iw_tgt_sr_we;
    ow_sr_waddr = iw_tgt_sr;
    ow_sr_wdata = iw_result;
  end

  assign ow_fwd0_we   = ow_gp_we;
  assign ow_fwd0_tgt  = ow_gp_waddr;
  assign ow_fwd0_data = ow_gp_wdata;

  always_comb begin
    fwd1_we_d   = ow_fwd0_we;
    fwd1_tgt_d  = ow_fwd0_tgt;
    fwd1_data_d = ow_fwd0_data;
  end

  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      fwd1_we_q   <= 1'b0;
      fwd1_tgt_q  <= '0;
      fwd1_data_q <= '0;
    end else begin
      fwd1_we_q   <= fwd1_we_d;
      fwd1_tgt_q  <= fwd1_tgt_d;
      fwd1_data_q <= fwd1_data_d;
    end
  end

  // A HALT retires in RUN and takes effect from the next cycle; resume in RUN is ignored.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q   <= StRun;
      halt_pc_q <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (iw_opc == OpcHalt) begin
            state_q   <= StHalted;
            halt_pc_q <= iw_pc;
          end
        end
        StHalted: begin
          if (iw_resume) begin
            state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  stg5wb_wb_counter #(
    .CntW (CNT_W)
  ) u_retired_cnt (
    .clk_i  (iw_clk),
    .rst_ni (iw_rst_n),
    .en_i   (retire),
    .cnt_o  (ow_retired),
    .ovf_o  (ow_retired_ovf)
  );

  stg5wb_wb_counter #(
    .CntW (CNT_W)
  ) u_cycles_cnt (
    .clk_i  (iw_clk),
    .rst_ni (iw_rst_n),
    .en_i   (in_run),
    .cnt_o  (ow_cycles),
    .ovf_o  (cycles_ovf_unused)
  );

  assign ow_fwd1_we   = fwd1_we_q;
  assign ow_fwd1_tgt  = fwd1_tgt_q;
  assign ow_fwd1_data = fwd1_data_q;
  assign ow_halted    = (state_q == StHalted);
  assign ow_halt_pc   = halt_pc_q;

endmodule
